// File: rtl/dot_result_drain.sv
// dot_result_drain
// Captures one parallel dot-product result (all lanes in one edge) into a
// local buffer and drains it as a serial valid/ready stream, one lane per
// beat. Produces the sign-derived spin vector at capture time and keeps two
// sticky error flags: overrun (a capture request arrived while a drain was
// still in progress) and misalign (the per-lane start pulses disagreed).

module dot_result_drain #(
   parameter int LANES            = 256,
   parameter int INT_RESULT_WIDTH = 13,
   parameter int LANE_IDX_W       = $clog2(LANES)
) (
   input  logic                               clk,
   input  logic                               rst_n,

   // Parallel result interface from the tree array
   input  logic signed [INT_RESULT_WIDTH-1:0] dot_ins     [LANES],
   input  logic                               start_ins   [LANES],

   // Serial result stream
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic signed [INT_RESULT_WIDTH-1:0] out_data,
   output logic        [LANE_IDX_W-1:0]       out_lane,
   output logic                               out_last,

   // Spin vector derived from the captured result
   output logic        [LANES-1:0]            sigma_next,
   output logic                               sigma_valid,

   // Status
   output logic                               busy,
   output logic                               overrun,
   output logic                               misalign,
   input  logic                               clear_flags
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                              state_q,       state_d;
   logic [LANE_IDX_W-1:0]               idx_q,         idx_d;
   logic [LANES-1:0]                    sigma_q,       sigma_d;
   logic                                sigma_valid_q, sigma_valid_d;
   logic                                overrun_q,     overrun_d;
   logic                                misalign_q,    misalign_d;
   logic signed [INT_RESULT_WIDTH-1:0]  buf_q [LANES];

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic             in_drain;
   logic             req;
   logic             xfer;
   logic             at_last;
   logic             capture;
   logic             drop;
   logic             lanes_disagree;
   logic [LANES-1:0] spin_now;

   // Flag any lane whose start pulse differs from the lane-0 reference.
   always_comb begin
      lanes_disagree = 1'b0;
      for (int l = 1; l < LANES; l++) begin
         if (start_ins[l] != start_ins[0]) begin
            lanes_disagree = 1'b1;
         end
      end
   end

   // Spin of each incoming lane: non-negative result (sign bit clear) maps to 1.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         spin_now[l] = ~dot_ins[l][INT_RESULT_WIDTH-1];
      end
   end

   // Handshake and capture decision. A request is honoured when idle, or when
   // the final beat is leaving in the same cycle so the stream stays gapless;
   // any other request during a drain is dropped.
   always_comb begin
      in_drain = (state_q == DRAIN);
      req      = start_ins[0];
      xfer     = in_drain && out_ready;
      at_last  = (idx_q == LANE_IDX_W'(LANES - 1));
      capture  = req && (!in_drain || (xfer && at_last));
      drop     = req && !capture;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // FSM, lane index, spin vector and sticky flags.
   always_comb begin
      // NOTE: every variable gets its hold value first so that no path through
      // the block leaves it unassigned, which would infer a latch.
      state_d       = state_q;
      idx_d         = idx_q;
      sigma_d       = sigma_q;
      sigma_valid_d = 1'b0;
      overrun_d     = overrun_q;
      misalign_d    = misalign_q;

      if (capture) begin
         state_d       = DRAIN;
         idx_d         = '0;
         sigma_d       = spin_now;
         sigma_valid_d = 1'b1;
      end else if (xfer) begin
         if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d   = idx_q + LANE_IDX_W'(1);
         end
      end

      // Sticky flags: a set event in the same cycle beats a clear.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (clear_flags) begin
         overrun_d = 1'b0;
      end

      if (lanes_disagree) begin
         misalign_d = 1'b1;
      end else if (clear_flags) begin
         misalign_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // Control state with synchronous active-low reset; reset also discards
   // any start request sampled in the same edge.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         sigma_q       <= '0;
         sigma_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         sigma_q       <= sigma_d;
         sigma_valid_q <= sigma_valid_d;
         overrun_q     <= overrun_d;
         misalign_q    <= misalign_d;
      end
   end

   // Result buffer, written only on an accepted capture.
   always_ff @(posedge clk) begin
      // NOTE: the buffer is deliberately not reset; it is only observable in
      // DRAIN, which can only be reached through a capture that overwrites it.
      if (rst_n && capture) begin
         buf_q <= dot_ins;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Stream and status outputs; data and lane are forced to zero outside DRAIN.
   always_comb begin
      busy        = in_drain;
      out_valid   = in_drain;
      out_lane    = in_drain ? idx_q : '0;
      out_data    = in_drain ? buf_q[idx_q] : '0;
      out_last    = in_drain && at_last;
      sigma_next  = sigma_q;
      sigma_valid = sigma_valid_q;
      overrun     = overrun_q;
      misalign    = misalign_q;
   end

endmodule

// File: tb/tb_dot_result_drain.sv
// Testbench for dot_result_drain (LANES=4, INT_RESULT_WIDTH=13).
// Directed table, hand-written corner sequences and a randomized phase, all
// compared against a queue-of-beats reference model.

module tb_dot_result_drain;

   localparam int LANES = 4;
   localparam int W     = 13;
   localparam int IW    = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic signed [W-1:0]  dot_ins   [LANES];
   logic                 start_ins [LANES];
   logic                 out_valid;
   logic                 out_ready;
   logic signed [W-1:0]  out_data;
   logic [IW-1:0]        out_lane;
   logic                 out_last;
   logic [LANES-1:0]     sigma_next;
   logic                 sigma_valid;
   logic                 busy;
   logic                 overrun;
   logic                 misalign;
   logic                 clear_flags;

   int checks = 0;
   int errors = 0;

   dot_result_drain #(
      .LANES            (LANES),
      .INT_RESULT_WIDTH (W),
      .LANE_IDX_W       (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dot_ins     (dot_ins),
      .start_ins   (start_ins),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_lane    (out_lane),
      .out_last    (out_last),
      .sigma_next  (sigma_next),
      .sigma_valid (sigma_valid),
      .busy        (busy),
      .overrun     (overrun),
      .misalign    (misalign),
      .clear_flags (clear_flags)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int lane;
      int data;
   } beat_t;

   beat_t            mq[$];      // beats still to be delivered, head = current
   logic [LANES-1:0] m_sigma;
   logic             m_sv;
   logic             m_ovr;
   logic             m_mis;

   task automatic model_update();
      logic any_mis;
      logic set_ovr;
      if (!rst_n) begin
         mq.delete();
         m_sigma = '0;
         m_sv    = 1'b0;
         m_ovr   = 1'b0;
         m_mis   = 1'b0;
         return;
      end
      any_mis = 1'b0;
      for (int l = 0; l < LANES; l++) if (start_ins[l] != start_ins[0]) any_mis = 1'b1;
      set_ovr = 1'b0;
      m_sv    = 1'b0;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (start_ins[0]) begin
         if (mq.size() == 0) begin
            for (int l = 0; l < LANES; l++) begin
               beat_t b;
               b.lane = l;
               b.data = int'(dot_ins[l]);
               mq.push_back(b);
               m_sigma[l] = (dot_ins[l] >= 0);
            end
            m_sv = 1'b1;
         end else begin
            set_ovr = 1'b1;
         end
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clear_flags) m_ovr = 1'b0;
      if (any_mis) m_mis = 1'b1;
      else if (clear_flags) m_mis = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic              e_valid;
      logic signed [31:0] e_lane;
      logic signed [31:0] e_data;
      e_valid = (mq.size() > 0);
      e_lane  = e_valid ? mq[0].lane : 0;
      e_data  = e_valid ? mq[0].data : 0;
      check("m_valid",   out_valid,   e_valid);
      check("m_lane",    out_lane,    e_lane);
      check("m_data",    out_data,    e_data);
      check("m_last",    out_last,    e_valid && (e_lane == LANES - 1));
      check("m_busy",    busy,        e_valid);
      check("m_sigma",   sigma_next,  m_sigma);
      check("m_sv",      sigma_valid, m_sv);
      check("m_overrun", overrun,     m_ovr);
      check("m_misalign",misalign,    m_mis);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_dots(input int a, input int b, input int c, input int d);
      dot_ins[0] = W'(a);
      dot_ins[1] = W'(b);
      dot_ins[2] = W'(c);
      dot_ins[3] = W'(d);
   endtask

   task automatic set_start(input logic [3:0] s);
      for (int l = 0; l < LANES; l++) start_ins[l] = s[l];
   endtask

   // One clock: drive control at the falling edge, let the rising edge happen,
   // advance the model and compare shortly after the edge.
   task automatic step(input logic rst, input logic rdy, input logic clr);
      @(negedge clk);
      rst_n       = rst;
      out_ready   = rdy;
      clear_flags = clr;
      @(posedge clk);
      model_update();
      #2;
      compare_model();
   endtask

   task automatic drain_out();
      set_start(4'b0000);
      for (int c = 0; c < 16 && out_valid; c++) step(1'b1, 1'b1, 1'b0);
      check("drain_done", out_valid, 1'b0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0] st;
      int         d0, d1, d2, d3;
      logic       rdy;
      logic       clr;
      logic       vld;
      int         lane;
      int         data;
      logic       last;
      logic [3:0] sig;
      logic       sv;
      logic       ovr;
      logic       mis;
   } vec_t;

   vec_t tbl [5];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int               nb;
      int               got_lane [4];
      int               got_data [4];
      logic             rdy;
      int               r;
      logic [3:0]       s;

      rst_n       = 1'b0;
      out_ready   = 1'b0;
      clear_flags = 1'b0;
      set_start(4'b0000);
      set_dots(0, 0, 0, 0);
      mq.delete();
      m_sigma = '0; m_sv = 1'b0; m_ovr = 1'b0; m_mis = 1'b0;

      // Reset with a start request present: must be ignored.
      set_start(4'b1111);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("rst_valid",   out_valid,   0);
      check("rst_data",    out_data,    0);
      check("rst_lane",    out_lane,    0);
      check("rst_last",    out_last,    0);
      check("rst_sigma",   sigma_next,  0);
      check("rst_sv",      sigma_valid, 0);
      check("rst_busy",    busy,        0);
      check("rst_overrun", overrun,     0);
      check("rst_misalign",misalign,    0);
      set_start(4'b0000);
      step(1'b1, 1'b1, 1'b0);
      check("post_rst_idle", out_valid, 0);

      // Basic capture and full-rate drain.
      tbl[0] = '{4'b1111, 5, -3, 0, -7, 1'b1, 1'b0, 1'b1, 0,  5, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{4'b0000, 0,  0, 0,  0, 1'b1, 1'b0, 1'b1, 1, -3, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{4'b0000, 0,  0, 0,  0, 1'b1, 1'b0, 1'b1, 2,  0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'b0000, 0,  0, 0,  0, 1'b1, 1'b0, 1'b1, 3, -7, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{4'b0000, 0,  0, 0,  0, 1'b1, 1'b0, 1'b0, 0,  0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         set_start(tbl[i].st);
         set_dots(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
         step(1'b1, tbl[i].rdy, tbl[i].clr);
         check($sformatf("t%0d_valid", i),   out_valid,   tbl[i].vld);
         check($sformatf("t%0d_lane", i),    out_lane,    tbl[i].lane);
         check($sformatf("t%0d_data", i),    out_data,    tbl[i].data);
         check($sformatf("t%0d_last", i),    out_last,    tbl[i].last);
         check($sformatf("t%0d_sigma", i),   sigma_next,  tbl[i].sig);
         check($sformatf("t%0d_sv", i),      sigma_valid, tbl[i].sv);
         check($sformatf("t%0d_busy", i),    busy,        tbl[i].vld);
         check($sformatf("t%0d_overrun", i), overrun,     tbl[i].ovr);
         check($sformatf("t%0d_misalign", i),misalign,    tbl[i].mis);
      end

      // Backpressure: ready pattern 1,0,0,1,0,0,...
      set_dots(5, -3, 0, -7);
      set_start(4'b1111);
      step(1'b1, 1'b0, 1'b0);
      set_start(4'b0000);
      nb = 0;
      for (int c = 0; c < 30 && nb < 4; c++) begin
         rdy = ((c % 3) == 0);
         if (out_valid && rdy) begin
            got_lane[nb] = int'(out_lane);
            got_data[nb] = int'(out_data);
            nb++;
         end
         step(1'b1, rdy, 1'b0);
      end
      check("bp_beats", nb, 4);
      check("bp_lane0", got_lane[0], 0); check("bp_data0", got_data[0], 5);
      check("bp_lane1", got_lane[1], 1); check("bp_data1", got_data[1], -3);
      check("bp_lane2", got_lane[2], 2); check("bp_data2", got_data[2], 0);
      check("bp_lane3", got_lane[3], 3); check("bp_data3", got_data[3], -7);
      check("bp_idle",  out_valid, 0);

      // Overrun: second start during the lane-1 beat.
      set_dots(5, -3, 0, -7);
      set_start(4'b1111);
      step(1'b1, 1'b1, 1'b0);
      set_start(4'b0000);
      step(1'b1, 1'b1, 1'b0);
      check("ov_lane1", out_lane, 1);
      set_dots(9, 9, 9, 9);
      set_start(4'b1111);
      step(1'b1, 1'b1, 1'b0);
      check("ov_flag",  overrun,    1);
      check("ov_lane2", out_lane,   2);
      check("ov_data2", out_data,   0);
      check("ov_sigma", sigma_next, 4'b0101);
      set_start(4'b0000);
      step(1'b1, 1'b1, 1'b0);
      check("ov_data3", out_data, -7);
      check("ov_last",  out_last, 1);
      step(1'b1, 1'b1, 1'b1);
      check("ov_clear", overrun,   0);
      check("ov_idle",  out_valid, 0);

      // Back-to-back capture on the final-beat handshake.
      set_dots(5, -3, 0, -7);
      set_start(4'b1111);
      step(1'b1, 1'b1, 1'b0);
      set_start(4'b0000);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
      check("b2b_last", out_last, 1);
      set_dots(-1, 1, -1, 1);
      set_start(4'b1111);
      step(1'b1, 1'b1, 1'b0);
      check("b2b_valid", out_valid,   1);
      check("b2b_lane0", out_lane,    0);
      check("b2b_data0", out_data,    -1);
      check("b2b_sigma", sigma_next,  4'b1010);
      check("b2b_sv",    sigma_valid, 1);
      check("b2b_ovr",   overrun,     0);
      set_start(4'b0000);
      step(1'b1, 1'b1, 1'b0); check("b2b_data1", out_data, 1);
      step(1'b1, 1'b1, 1'b0); check("b2b_data2", out_data, -1);
      step(1'b1, 1'b1, 1'b0); check("b2b_data3", out_data, 1);
      step(1'b1, 1'b1, 1'b0); check("b2b_idle",  out_valid, 0);

      // Misalign: lane 2 disagrees, capture still happens, flag sticks.
      set_dots(3, 4, -5, 6);
      set_start(4'b1011);
      step(1'b1, 1'b1, 1'b0);
      check("mis_busy", busy,     1);
      check("mis_flag", misalign, 1);
      drain_out();
      check("mis_sticky", misalign, 1);
      step(1'b1, 1'b1, 1'b1);
      check("mis_clear", misalign, 0);

      // Reset after the lane-1 beat abandons the drain.
      set_dots(7, -8, 9, -10);
      set_start(4'b1111);
      step(1'b1, 1'b1, 1'b0);
      set_start(4'b0000);
      step(1'b1, 1'b1, 1'b0);
      check("rm_lane1", out_lane, 1);
      set_start(4'b1111);
      step(1'b0, 1'b1, 1'b0);
      check("rm_valid", out_valid,  0);
      check("rm_data",  out_data,   0);
      check("rm_lane",  out_lane,   0);
      check("rm_sigma", sigma_next, 0);
      check("rm_busy",  busy,       0);
      set_start(4'b0000);
      step(1'b1, 1'b1, 1'b0);
      check("rm_no_beat", out_valid, 0);
      set_dots(2, 3, 4, 5);
      set_start(4'b1111);
      step(1'b1, 1'b1, 1'b0);
      check("rm_fresh_lane", out_lane, 0);
      check("rm_fresh_data", out_data, 2);
      drain_out();

      // Randomized traffic against the model.
      for (int c = 0; c < 800; c++) begin
         r = $urandom_range(0, 99);
         if (r < 18)      s = 4'b1111;
         else if (r < 21) s = 4'($urandom_range(0, 15));
         else             s = 4'b0000;
         set_start(s);
         for (int l = 0; l < LANES; l++) dot_ins[l] = W'($urandom_range(0, 8191));
         step(($urandom_range(0, 149) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0));
      end
      drain_out();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dot_result_drain.md
DOT_RESULT_DRAIN -- requirements
Module: dot_result_drain

Interface
REQ-001 SHALL have parameter LANES, default 256: number of parallel dot-product lanes captured per result.
REQ-002 SHALL have parameter INT_RESULT_WIDTH, default 13: signed width of each lane result.
REQ-003 SHALL have parameter LANE_IDX_W, default $clog2(LANES): width of lane index output.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port dot_ins  input  LANES x INT_RESULT_WIDTH (signed, unpacked [LANES])  per-lane dot-product results from the tree array.
REQ-007 SHALL have port start_ins  input  LANES x 1 (unpacked [LANES])  per-lane result-valid pulses from the tree array.
REQ-008 SHALL have port out_valid  output  1  serial result beat valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port out_data  output  INT_RESULT_WIDTH (signed)  captured result of lane out_lane.
REQ-011 SHALL have port out_lane  output  LANE_IDX_W  lane index of current beat.
REQ-012 SHALL have port out_last  output  1  high on the beat for lane LANES-1.
REQ-013 SHALL have port sigma_next  output  LANES  spin vector derived from captured results.
REQ-014 SHALL have port sigma_valid  output  1  one-cycle pulse when sigma_next updates.
REQ-015 SHALL have port busy  output  1  high while in DRAIN.
REQ-016 SHALL have port overrun  output  1  sticky: capture request dropped.
REQ-017 SHALL have port misalign  output  1  sticky: start_ins lanes disagreed.
REQ-018 SHALL have port clear_flags  input  1  synchronous clear of overrun and misalign.

Function
REQ-019 SHALL use start_ins[0] as the capture request; other lanes are checked only for misalign.
REQ-020 SHALL set misalign on any cycle where some start_ins[l] != start_ins[0].
REQ-021 SHALL implement FSM states IDLE and DRAIN.
REQ-022 In IDLE with start_ins[0]=1: SHALL register all dot_ins into an internal buffer, set idx=0, enter DRAIN at the same edge.
REQ-023 At capture edge SHALL register sigma_next[l] = 1 if dot_ins[l] >= 0, else 0, and assert sigma_valid for exactly the following cycle.
REQ-024 In DRAIN: out_valid=1, out_data=buffer[idx], out_lane=idx, out_last=(idx==LANES-1); in IDLE out_valid=out_last=0.
REQ-025 Beat transfers when out_valid && out_ready; on transfer idx increments; out_data/out_lane SHALL hold stable while out_valid && !out_ready.
REQ-026 On transfer with out_last=1 and start_ins[0]=0: SHALL return to IDLE.
REQ-027 On transfer with out_last=1 and start_ins[0]=1 in the same cycle: SHALL capture the new result (REQ-022/023), remain in DRAIN, idx=0; overrun not set.
REQ-028 start_ins[0]=1 in DRAIN other than REQ-027: SHALL drop the request, set overrun, leave buffer, idx, sigma_next unchanged.
REQ-029 Capture latency: request sampled at edge N -> out_valid high in cycle N+1; minimum drain LANES cycles with out_ready held high.
REQ-030 clear_flags=1 SHALL clear overrun and misalign; if a set condition occurs in the same cycle, set wins.
REQ-031 busy SHALL equal (state==DRAIN).
REQ-032 Buffer SHALL keep full INT_RESULT_WIDTH signed values without truncation or extension.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force IDLE, idx=0, out_valid=0, out_last=0, out_data=0, out_lane=0, sigma_next=0, sigma_valid=0, busy=0, overrun=0, misalign=0.
REQ-034 Reset asserted mid-DRAIN SHALL abandon the drain; no beat after reset until a new capture.
REQ-035 start_ins sampled while rst_n=0 SHALL be ignored.

Verification (LANES=4, INT_RESULT_WIDTH=13)
REQ-036 Basic: dot_ins={5,-3,0,-7}, start pulse, out_ready=1 -> beats (lane,data)=(0,5),(1,-3),(2,0),(3,-7), out_last on 4th only, sigma_next=4'b0101, sigma_valid one cycle.
REQ-037 Backpressure: as REQ-036 with out_ready toggled 1,0,0,1,... -> identical beat sequence, data/lane stable during stalls.
REQ-038 Overrun: second start pulse during lane-1 beat -> overrun=1, remaining beats from first capture unchanged; clear_flags -> overrun=0.
REQ-039 Back-to-back: new start on final-beat handshake with dot_ins={-1,1,-1,1} -> no idle cycle, next beats -1,1,-1,1, sigma_next=4'b1010, overrun=0.
REQ-040 Misalign: start_ins={1,1,0,1} -> capture occurs, misalign=1 sticky.
REQ-041 Reset mid-drain after lane-1 beat -> all outputs at REQ-033 values next cycle; fresh capture drains from lane 0.
